// File: rtl/source_gen.sv
`default_nettype none
// ============================================================================
//  Module   : source_gen
//  Purpose  : Speech excitation source. A nonzero period gives an impulse
//             train; period 0 gives LFSR-signed noise. One sample per strobe.
//             Optional macro SOURCE_AMP_RAMP_EN slew-limits the amplitude.
//  Revision : 1.0  initial release
// ============================================================================
module source_gen #(
  parameter int OUT_W     = 16,
  parameter int AMP_W     = 15,
  parameter int PERIOD_W  = 8,
  parameter int RAMP_STEP = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       strobe,
  input  logic        [PERIOD_W-1:0] period,
  input  logic signed [AMP_W-1:0]    amplitude,
  output logic signed [OUT_W-1:0]    source_out,
  output logic                       out_valid,
  output logic                       period_done
);

  localparam int                      c_lfsr_w    = 17;
  localparam logic [c_lfsr_w-1:0]     c_lfsr_seed = 17'h00001;
  localparam logic signed [AMP_W-1:0] c_amp_min   = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic signed [AMP_W-1:0] c_amp_max   = {1'b0, {(AMP_W-1){1'b1}}};

  if ((OUT_W < AMP_W + 1) || (RAMP_STEP < 1)) begin : g_bad_params
    $error("source_gen: need OUT_W >= AMP_W+1 and RAMP_STEP >= 1");
  end

  logic        [PERIOD_W-1:0] r_period_lat;
  logic        [PERIOD_W-1:0] r_cnt;
  logic        [c_lfsr_w-1:0] r_lfsr;
  logic signed [AMP_W-1:0]    r_amp_cur;

  logic signed [AMP_W-1:0]    w_amp_next;
  logic signed [AMP_W-1:0]    w_amp_neg;
  logic signed [AMP_W-1:0]    w_noise_val;
  logic        [c_lfsr_w-1:0] w_lfsr_next;
  logic        [PERIOD_W-1:0] w_period_m1;
  logic signed [OUT_W-1:0]    w_noise_ext;
  logic signed [OUT_W-1:0]    w_pulse_ext;
  logic                       w_noise_mode;

`ifdef SOURCE_AMP_RAMP_EN
  localparam logic signed [AMP_W:0] c_ramp_step = (AMP_W+1)'(RAMP_STEP);

  logic signed [AMP_W:0] w_diff;

  // Extra bit on the difference so a full-scale swing cannot wrap.
  always_comb begin
    w_diff = {amplitude[AMP_W-1], amplitude} - {r_amp_cur[AMP_W-1], r_amp_cur};
    if (w_diff > c_ramp_step) begin
      w_amp_next = r_amp_cur + c_ramp_step[AMP_W-1:0];
    end else if (w_diff < -c_ramp_step) begin
      w_amp_next = r_amp_cur - c_ramp_step[AMP_W-1:0];
    end else begin
      w_amp_next = amplitude;
    end
  end
`else
  assign w_amp_next = amplitude;
`endif

  assign w_noise_mode = (r_period_lat == '0);
  assign w_period_m1  = (period == '0) ? '0 : period - 1'b1;

  // Fibonacci x^17 + x^14 + 1; the fresh feedback bit lands in bit 0.
  assign w_lfsr_next  = {r_lfsr[c_lfsr_w-2:0], r_lfsr[16] ^ r_lfsr[13]};

  // The most negative amplitude has no positive twin, so clamp it.
  assign w_amp_neg    = (w_amp_next == c_amp_min) ? c_amp_max : -w_amp_next;
  assign w_noise_val  = w_lfsr_next[0] ? w_amp_next : w_amp_neg;

  assign w_noise_ext  = {{(OUT_W-AMP_W){w_noise_val[AMP_W-1]}}, w_noise_val};
  assign w_pulse_ext  = {{(OUT_W-AMP_W){w_amp_next[AMP_W-1]}}, w_amp_next};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      source_out   <= '0;
      out_valid    <= 1'b0;
      period_done  <= 1'b0;
      r_period_lat <= '0;
      r_cnt        <= '0;
      r_lfsr       <= c_lfsr_seed;
      r_amp_cur    <= '0;
    end else begin
      out_valid   <= strobe;
      period_done <= 1'b0;
      if (strobe) begin
        r_amp_cur <= w_amp_next;
        if (w_noise_mode) begin
          r_lfsr       <= w_lfsr_next;
          source_out   <= w_noise_ext;
          r_period_lat <= period;
          r_cnt        <= w_period_m1;
        end else if (r_cnt == '0) begin
          // Period boundary: emit the pulse and pick up any new period.
          source_out   <= w_pulse_ext;
          r_period_lat <= period;
          r_cnt        <= w_period_m1;
          period_done  <= 1'b1;
        end else begin
          source_out   <= '0;
          r_cnt        <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
